// File: rtl/am_audio_decimator.sv
// Boxcar-average decimator with leaky-integrator DC removal for the AM envelope path.
// Optional build macro AM_DC_PRELOAD_EN: the first average after reset seeds the DC tracker.
module am_audio_decimator #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int DECIM_LOG2   = 8,
    parameter int DC_SHIFT     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  amdemod_in,
    input  logic                    in_valid,
    output logic [OUTPUT_WIDTH-1:0] audio_out,
    output logic                    audio_valid
);

    localparam int ACC_W  = INPUT_WIDTH + DECIM_LOG2;
    localparam int DC_W   = INPUT_WIDTH + DC_SHIFT;
    localparam int DIFF_W = INPUT_WIDTH + 1;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic [DECIM_LOG2-1:0]     cnt;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          acc_sum;
    logic [INPUT_WIDTH-1:0]    avg;
    logic                      avg_valid;
    logic                      block_done;

    logic [DC_W-1:0]           dc_acc;
    logic [DC_W-1:0]           dc_acc_next;
    logic [INPUT_WIDTH-1:0]    dc_est;
    logic signed [DIFF_W-1:0]  diff;
    logic signed [DC_W-1:0]    diff_ext;
    logic [OUTPUT_WIDTH-1:0]   audio_sat;

    // The final sample of a block joins that block; acc restarts from zero.
    assign acc_sum    = acc + ACC_W'(amdemod_in);
    assign block_done = in_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (in_valid) begin
                cnt <= cnt + DECIM_LOG2'(1);
                if (block_done) begin
                    avg       <= acc_sum[ACC_W-1:DECIM_LOG2];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign dc_est      = dc_acc[DC_W-1:DC_SHIFT];
    assign diff        = $signed({1'b0, avg}) - $signed({1'b0, dc_est});
    assign diff_ext    = DC_W'(diff);
    assign dc_acc_next = dc_acc + $unsigned(diff_ext);

    generate
        if (OUTPUT_WIDTH <= INPUT_WIDTH) begin : g_sat
            localparam int SAT_MAX_I = (1 << (OUTPUT_WIDTH - 1)) - 1;
            localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'(SAT_MAX_I);
            localparam logic signed [DIFF_W-1:0] SAT_MIN = DIFF_W'(-SAT_MAX_I - 1);

            always_comb begin
                audio_sat = diff[OUTPUT_WIDTH-1:0];
                if (diff > SAT_MAX) begin
                    audio_sat = SAT_MAX[OUTPUT_WIDTH-1:0];
                end else if (diff < SAT_MIN) begin
                    audio_sat = SAT_MIN[OUTPUT_WIDTH-1:0];
                end
            end
        end else begin : g_ext
            // Output is at least as wide as diff, so sign extension is lossless.
            assign audio_sat = OUTPUT_WIDTH'(diff);
        end
    endgenerate

`ifdef AM_DC_PRELOAD_EN
    logic first_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_acc      <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            first_done  <= 1'b0;
        end else begin
            audio_valid <= avg_valid;
            if (avg_valid) begin
                if (!first_done) begin
                    // Seed the tracker at the carrier level so start-up gives no thump.
                    dc_acc     <= {avg, {DC_SHIFT{1'b0}}};
                    audio_out  <= '0;
                    first_done <= 1'b1;
                end else begin
                    dc_acc    <= dc_acc_next;
                    audio_out <= audio_sat;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_acc      <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
        end else begin
            audio_valid <= avg_valid;
            if (avg_valid) begin
                dc_acc    <= dc_acc_next;
                audio_out <= audio_sat;
            end
        end
    end
`endif

endmodule
